// File: rtl/armleocpu_tlb_unit.sv
// armleocpu_tlb_unit
//   Set-associative TLB translating a 20-bit Sv32 virtual page tag into a
//   22-bit physical page tag and an 8-bit access tag {D,A,G,U,X,W,R,V}.
//   The lookup result is registered and presented one cycle after resolve.
//   Refill replaces entries as follows: an entry already holding the same
//   tag, else the lowest free way, else the set's round-robin victim.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   enable             1 = translate, 0 = bare pass-through
//   virtual_address    vtag to resolve
//   invalidate         flush all entries (wins over write and resolve)
//   resolve            lookup request
//   miss, done         registered lookup status (done is a 1-cycle pulse)
//   accesstag_r        registered access tag
//   phys_r             registered physical page tag
//   write              refill request
//   virtual_address_w  vtag to refill
//   accesstag_w        access tag to store
//   phys_w             ptag to store
module armleocpu_tlb_unit #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS_W    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [19:0] virtual_address,
  input  logic        invalidate,
  input  logic        resolve,
  output logic        miss,
  output logic        done,
  output logic [7:0]  accesstag_r,
  output logic [21:0] phys_r,
  input  logic        write,
  input  logic [19:0] virtual_address_w,
  input  logic [7:0]  accesstag_w,
  input  logic [21:0] phys_w
);

  localparam int SETS  = 1 << ENTRIES_W;
  localparam int WAYS  = 1 << WAYS_W;
  localparam int TAG_W = 20 - ENTRIES_W;

  // Pass-through permissions: D,A,X,W,R,V set; G,U clear.
  localparam logic [7:0] BARE_ACCESSTAG = 8'b1100_1111;

  logic [WAYS-1:0]   valid         [SETS];
  logic [WAYS_W-1:0] victim        [SETS];
  logic [TAG_W-1:0]  tag_mem       [SETS][WAYS];
  logic [7:0]        accesstag_mem [SETS][WAYS];
  logic [21:0]       phys_mem      [SETS][WAYS];

  // ---------------------------------------------------------------- lookup
  logic [ENTRIES_W-1:0] rd_set;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_hit;
  logic [7:0]           rd_accesstag;
  logic [21:0]          rd_phys;

  assign rd_set = virtual_address[ENTRIES_W-1:0];
  assign rd_tag = virtual_address[19:ENTRIES_W];

  // NOTE: every always_comb output gets a default first so no latch is
  // inferred when no way matches.
  always_comb begin
    rd_hit       = 1'b0;
    rd_accesstag = '0;
    rd_phys      = '0;
    // Scan from the top so the lowest-numbered hitting way is the last
    // assignment and therefore wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[rd_set][i] && tag_mem[rd_set][i] == rd_tag) begin
        rd_hit       = 1'b1;
        rd_accesstag = accesstag_mem[rd_set][i];
        rd_phys      = phys_mem[rd_set][i];
      end
    end
  end

  // ------------------------------------------------------- way selection
  logic [ENTRIES_W-1:0] wr_set;
  logic [TAG_W-1:0]     wr_tag;
  logic                 wr_en;
  logic                 match_found;
  logic [WAYS_W-1:0]    match_way;
  logic                 free_found;
  logic [WAYS_W-1:0]    free_way;
  logic [WAYS_W-1:0]    wr_way;
  logic                 bump_victim;

  assign wr_set = virtual_address_w[ENTRIES_W-1:0];
  assign wr_tag = virtual_address_w[19:ENTRIES_W];
  assign wr_en  = write && !invalidate;

  always_comb begin
    match_found = 1'b0;
    match_way   = '0;
    free_found  = 1'b0;
    free_way    = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[wr_set][i] && tag_mem[wr_set][i] == wr_tag) begin
        match_found = 1'b1;
        match_way   = WAYS_W'(i);
      end
      if (!valid[wr_set][i]) begin
        free_found = 1'b1;
        free_way   = WAYS_W'(i);
      end
    end
  end

  assign bump_victim = !match_found && !free_found;
  assign wr_way      = match_found ? match_way
                     : free_found  ? free_way
                     : victim[wr_set];

  // ------------------------------------------------- valid bits / victims
  // NOTE: sequential state uses non-blocking assignments so every reader in
  // this cycle sees the pre-edge value (lookup sees old contents on a
  // same-cycle write).
  always_ff @(posedge clk) begin
    if (!rst_n || invalidate) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        victim[s] <= '0;
      end
    end else if (write) begin
      valid[wr_set][wr_way] <= 1'b1;
      if (bump_victim)
        victim[wr_set] <= victim[wr_set] + 1'b1;
    end
  end

  // NOTE: payload arrays carry no reset; an entry is only observable once
  // its valid bit is set, so clearing them would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_set][wr_way]       <= wr_tag;
      accesstag_mem[wr_set][wr_way] <= accesstag_w;
      phys_mem[wr_set][wr_way]      <= phys_w;
    end
  end

  // ---------------------------------------------------------- result regs
  logic accept;
  assign accept = resolve && !invalidate;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done        <= 1'b0;
      miss        <= 1'b0;
      accesstag_r <= '0;
      phys_r      <= '0;
    end else begin
      done <= accept;
      if (accept) begin
        if (enable) begin
          miss        <= !rd_hit;
          accesstag_r <= rd_accesstag;
          phys_r      <= rd_phys;
        end else begin
          miss        <= 1'b0;
          accesstag_r <= BARE_ACCESSTAG;
          phys_r      <= {2'b00, virtual_address};
        end
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_tlb_unit.sv
// Testbench for armleocpu_tlb_unit: directed test-plan sequences followed by
// randomized traffic. A stimulus process predicts each cycle's outputs from
// a behavioural TLB model and queues them; a monitor on the falling edge
// pops and compares.
module tb_armleocpu_tlb_unit;

  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [19:0] virtual_address = '0;
  logic        invalidate = 1'b0;
  logic        resolve = 1'b0;
  logic        miss;
  logic        done;
  logic [7:0]  accesstag_r;
  logic [21:0] phys_r;
  logic        write = 1'b0;
  logic [19:0] virtual_address_w = '0;
  logic [7:0]  accesstag_w = '0;
  logic [21:0] phys_w = '0;

  armleocpu_tlb_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .virtual_address   (virtual_address),
    .invalidate        (invalidate),
    .resolve           (resolve),
    .miss              (miss),
    .done              (done),
    .accesstag_r       (accesstag_r),
    .phys_r            (phys_r),
    .write             (write),
    .virtual_address_w (virtual_address_w),
    .accesstag_w       (accesstag_w),
    .phys_w            (phys_w)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    bit        done;
    bit        miss;
    bit [21:0] phys;
    bit [7:0]  acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("done", 64'(done), 64'(e.done));
      check("result{miss,phys,acc}", 64'({miss, phys_r, accesstag_r}),
            64'({e.miss, e.phys, e.acc}));
    end
  end

  // ------------------------------------------------------------- the model
  // Each set is a small table of entries; lookups take the first matching
  // entry, refills follow the replacement rules directly.
  typedef struct {
    bit        v;
    bit [19:0] vtag;
    bit [7:0]  acc;
    bit [21:0] phys;
  } ent_t;

  ent_t      tlb[SETS][WAYS];
  int        vict[SETS];
  bit        h_miss;
  bit [21:0] h_phys;
  bit [7:0]  h_acc;

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      vict[s] = 0;
      for (int w = 0; w < WAYS; w++) tlb[s][w].v = 1'b0;
    end
  endfunction

  task automatic model_write(input bit [19:0] va, input bit [7:0] a,
                             input bit [21:0] p);
    int s;
    int way;
    s   = int'(va) % SETS;
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (way < 0 && tlb[s][w].v && tlb[s][w].vtag == va) way = w;
    for (int w = 0; w < WAYS; w++)
      if (way < 0 && !tlb[s][w].v) way = w;
    if (way < 0) begin
      way     = vict[s];
      vict[s] = (vict[s] + 1) % WAYS;
    end
    tlb[s][way].v    = 1'b1;
    tlb[s][way].vtag = va;
    tlb[s][way].acc  = a;
    tlb[s][way].phys = p;
  endtask

  // One clock cycle: apply inputs, predict, let the edge happen, queue the
  // prediction for the monitor.
  task automatic cycle(input bit r, input bit en, input bit res, input bit inv,
                       input bit wr, input bit [19:0] va, input bit [19:0] vaw,
                       input bit [7:0] aw, input bit [21:0] pw);
    exp_t e;
    rst_n             = r;
    enable            = en;
    resolve           = res;
    invalidate        = inv;
    write             = wr;
    virtual_address   = va;
    virtual_address_w = vaw;
    accesstag_w       = aw;
    phys_w            = pw;
    if (!r) begin
      model_clear();
      h_miss = 1'b0;
      h_phys = '0;
      h_acc  = '0;
      e.done = 1'b0;
    end else begin
      e.done = res && !inv;
      if (e.done) begin
        if (!en) begin
          h_miss = 1'b0;
          h_phys = {2'b00, va};
          h_acc  = 8'hCF;
        end else begin
          int s;
          bit hit;
          s   = int'(va) % SETS;
          hit = 1'b0;
          for (int w = 0; w < WAYS; w++) begin
            if (!hit && tlb[s][w].v && tlb[s][w].vtag == va) begin
              hit    = 1'b1;
              h_phys = tlb[s][w].phys;
              h_acc  = tlb[s][w].acc;
            end
          end
          h_miss = !hit;
          if (!hit) begin
            h_phys = '0;
            h_acc  = '0;
          end
        end
      end
      if (inv) model_clear();
      else if (wr) model_write(vaw, aw, pw);
    end
    e.miss = h_miss;
    e.phys = h_phys;
    e.acc  = h_acc;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cycle(1, 1, 0, 0, 0, 20'h0, 20'h0, 8'h0, 22'h0);
  endtask

  task automatic lookup(input bit en, input bit [19:0] va);
    cycle(1, en, 1, 0, 0, va, 20'h0, 8'h0, 22'h0);
  endtask

  task automatic refill(input bit [19:0] va, input bit [7:0] a,
                        input bit [21:0] p);
    cycle(1, 1, 0, 0, 1, 20'h0, va, a, p);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    model_clear();
    h_miss = 1'b0;
    h_phys = '0;
    h_acc  = '0;

    // Reset, then a miss on an empty TLB.
    cycle(0, 1, 0, 0, 0, 20'h0, 20'h0, 8'h0, 22'h0);
    cycle(0, 1, 1, 0, 0, 20'h12345, 20'h0, 8'h0, 22'h0);
    lookup(1, 20'h12345);
    idle();

    // Refill then hit; same set with another tag misses.
    refill(20'h12345, 8'hCF, 22'h2ABCD);
    lookup(1, 20'h12345);
    lookup(1, 20'h02345);
    idle();

    // Bare mode ignores contents.
    lookup(0, 20'hFFFFF);
    lookup(0, 20'h12345);

    // Replacement in set 1: fill both ways, third evicts way 0.
    refill(20'h00001, 8'h11, 22'h00A01);
    refill(20'h00011, 8'h13, 22'h00A11);
    refill(20'h00021, 8'h15, 22'h00A21);
    lookup(1, 20'h00001);
    lookup(1, 20'h00011);
    lookup(1, 20'h00021);
    // Rewrite of an existing tag updates in place, no eviction.
    refill(20'h00011, 8'h17, 22'h3FFFF);
    lookup(1, 20'h00021);
    lookup(1, 20'h00011);

    // Resolve and write to the same entry in one cycle sees old contents.
    cycle(1, 1, 1, 0, 1, 20'h00042, 20'h00042, 8'h5B, 22'h12345);
    lookup(1, 20'h00042);

    // Invalidate beats write and resolve.
    cycle(1, 1, 1, 1, 1, 20'h00011, 20'h00031, 8'hFF, 22'h11111);
    lookup(1, 20'h00011);
    lookup(1, 20'h00031);
    lookup(1, 20'h12345);

    // Reset right after a resolve drops the result and the contents.
    refill(20'h12345, 8'hCF, 22'h2ABCD);
    lookup(1, 20'h12345);
    cycle(0, 1, 1, 0, 0, 20'h12345, 20'h0, 8'h0, 22'h0);
    lookup(1, 20'h12345);
    idle();

    // Random traffic over a narrow tag pool so hits and evictions happen.
    for (int n = 0; n < 3000; n++) begin
      bit [19:0] va;
      bit [19:0] vaw;
      va  = {16'($urandom_range(0, 5)), 4'($urandom_range(0, 2))};
      vaw = {16'($urandom_range(0, 5)), 4'($urandom_range(0, 2))};
      cycle($urandom_range(0, 199) != 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 4,
            va, vaw, 8'($urandom), 22'($urandom));
    end

    idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/armleocpu_tlb_unit.md
Name: armleocpu_tlb_unit

Overview:
- Data/instruction TLB that translates a 20-bit Sv32 virtual page tag into a 22-bit physical page tag plus an 8-bit access tag.
- Sits beside the cache; the cache issues `resolve` in its idle state and consumes the result one cycle later.
- Refilled by the page-table walker through a write port.
- Flushed in full by `invalidate`.

Parameters:
- ENTRIES_W, 4: log2 of the number of sets. Set index = virtual_address[ENTRIES_W-1:0]; stored tag = virtual_address[19:ENTRIES_W].
- WAYS_W, 1: log2 of the associativity.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  1 = translation on (satp.MODE); 0 = bare pass-through.
- virtual_address  input  20  vtag to resolve.
- invalidate  input  1  clears every entry.
- resolve  input  1  lookup request.
- miss  output  1  registered; 1 = no valid matching entry.
- done  output  1  registered; one-cycle pulse, result valid.
- accesstag_r  output  8  registered access tag {D,A,G,U,X,W,R,V}.
- phys_r  output  22  registered physical page tag.
- write  input  1  refill request.
- virtual_address_w  input  20  vtag to refill.
- accesstag_w  input  8  access tag to store.
- phys_w  input  22  ptag to store.

Behaviour:
- Storage per way per set: valid bit, tag (20-ENTRIES_W bits), accesstag (8), phys (22). One victim counter (WAYS_W bits) per set.
- Reset (rst_n=0 at a clk edge):
  - all valid bits, victim counters, done, miss, accesstag_r and phys_r go to 0;
  - a reset in the middle of a lookup drops the result (done=0 next cycle).
- Lookup latency is exactly 1 cycle. `resolve` sampled high at edge N gives done=1 during cycle N+1.
- done is 1 only in the cycle after an accepted resolve; otherwise 0.
- A resolve is accepted only when invalidate=0 in the same cycle. If invalidate=1, the resolve is dropped (no done).
- Result when enable=1:
  - hit = a valid way in set index whose tag equals virtual_address[19:ENTRIES_W];
  - on a hit: miss=0, phys_r/accesstag_r come from the lowest-numbered hitting way;
  - on no hit: miss=1, phys_r=0, accesstag_r=0.
- Result when enable=0: miss=0, phys_r={2'b00, virtual_address}, accesstag_r=8'b1100_1111 (D,A,X,W,R,V set; G,U clear). Stored entries are ignored.
- miss/phys_r/accesstag_r hold their last value until the next accepted resolve.
- The lookup reads state from before the edge. If a resolve and a write to the same set happen in the same cycle, the resolve sees the old contents.
- Write (write=1 and invalidate=0), way selection in priority order:
  1. a valid way already holding the same tag (it is overwritten);
  2. otherwise the lowest-numbered invalid way;
  3. otherwise the way named by the set's victim counter, and that counter then increments, wrapping modulo 2^WAYS_W.
- Every write stores tag, accesstag_w and phys_w, and sets valid=1. It is visible to a resolve in the next cycle.
- Invalidate clears all valid bits in one cycle. It takes priority over a write in the same cycle (the write is discarded) and resets all victim counters to 0.
- resolve and write may be asserted together. write without resolve produces no done.
- enable is sampled together with resolve; changing it between cycles needs no invalidate.
- All inputs are treated as synchronous. There is no internal stall; a resolve is accepted every cycle.

Test Plan:
- Reset, then enable=1, resolve vtag 0x12345 → next cycle done=1, miss=1, phys_r=0, accesstag_r=0; the cycle after, done=0.
- Write vtag 0x12345 with phys 0x2ABCD and accesstag 0xCF; next cycle resolve 0x12345 → done=1, miss=0, phys_r=0x2ABCD, accesstag_r=0xCF. Resolve 0x02345 (same set, other tag) → miss=1.
- enable=0, resolve 0xFFFFF → done=1, miss=0, phys_r=0x0FFFFF, accesstag_r=0xCF, whatever the TLB contents.
- Defaults (2 ways): write vtags 0x00001, 0x00011, 0x00021 (all set 1) → first two fill ways 0 and 1, third replaces way 0 per the victim counter. Then resolve 0x00001 → miss; 0x00011 and 0x00021 → hit.
- Fill an entry, assert invalidate together with write and resolve → no done next cycle. Resolve afterwards → miss=1 for both the old entry and the discarded write.
- Assert rst_n=0 in the cycle after resolve → done=0 and all entries are gone; a following resolve of a previously written vtag → miss=1.
